// File: rtl/traffic_timer_pkg.sv
// Shared slot encodings, default interval lengths and timer state type.
package traffic_timer_pkg;

  typedef enum logic [1:0] {
    BASE = 2'b00,
    EXT  = 2'b01,
    YEL  = 2'b10,
    WALK = 2'b11
  } slot_t;

  localparam logic [3:0] T_BASE_DEF = 4'd6;
  localparam logic [3:0] T_EXT_DEF  = 4'd3;
  localparam logic [3:0] T_YEL_DEF  = 4'd2;
  localparam logic [3:0] T_WALK_DEF = 4'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [3:0] default_value(input slot_t s);
    case (s)
      BASE:    return T_BASE_DEF;
      EXT:     return T_EXT_DEF;
      YEL:     return T_YEL_DEF;
      default: return T_WALK_DEF;
    endcase
  endfunction

endpackage

// File: rtl/one_hz_divider.sv
// Free-running tick divider: counts 0..CLKS_PER_TICK-1, registered one-cycle tick
// after the terminal count; clear restarts the phase so a fresh countdown gets full seconds.
module one_hz_divider #(
  parameter int CLKS_PER_TICK = 100_000_000
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  output logic oneHz_enable
);

  localparam int W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_TICK - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (Reset || clear) begin
      cnt          <= '0;
      oneHz_enable <= 1'b0;
    end else if (cnt == LAST) begin
      cnt          <= '0;
      oneHz_enable <= 1'b1;
    end else begin
      cnt          <= cnt + W'(1);
      oneHz_enable <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_timer.sv
// Programmable interval timer for the traffic-light controller: four reprogrammable
// second-count slots, IDLE/RUN countdown on a 1 Hz tick, registered Expired pulse.
module traffic_timer
  import traffic_timer_pkg::*;
#(
  parameter int CLKS_PER_TICK = 100_000_000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Reprogram,
  input  logic [1:0] Time_Parameter_Selector,
  input  logic [3:0] Time_Value,
  input  logic       Start_Timer,
  input  logic [1:0] Interval,
  output logic       Expired,
  output logic       Busy,
  output logic [3:0] Count,
  output logic       oneHz_enable,
  output logic [3:0] Param_Value
);

  logic [3:0] params [4];
  state_t     state;

  one_hz_divider #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_div (
    .clk          (clk),
    .Reset        (Reset),
    .clear        (Start_Timer),
    .oneHz_enable (oneHz_enable)
  );

  assign Param_Value = params[Time_Parameter_Selector];

  // A zero write restores the slot default so an interval can never be programmed to 0.
  always_ff @(posedge clk) begin
    if (Reset) begin
      params[BASE] <= T_BASE_DEF;
      params[EXT]  <= T_EXT_DEF;
      params[YEL]  <= T_YEL_DEF;
      params[WALK] <= T_WALK_DEF;
    end else if (Reprogram) begin
      params[Time_Parameter_Selector] <= (Time_Value != 4'd0)
          ? Time_Value : default_value(slot_t'(Time_Parameter_Selector));
    end
  end

  // Start beats the final tick; the load reads the pre-write slot value.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= IDLE;
      Count   <= 4'd0;
      Busy    <= 1'b0;
      Expired <= 1'b0;
    end else begin
      Expired <= 1'b0;
      if (Start_Timer) begin
        state <= RUN;
        Busy  <= 1'b1;
        Count <= params[Interval];
      end else if (state == RUN && oneHz_enable) begin
        if (Count <= 4'd1) begin
          state   <= IDLE;
          Busy    <= 1'b0;
          Count   <= 4'd0;
          Expired <= 1'b1;
        end else begin
          Count <= Count - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench: per-cycle arithmetic reference model, a vector table,
// directed corner sequences and a randomized phase.
module tb_traffic_timer;

  localparam int C = 10;

  logic       clk = 1'b0;
  logic       Reset = 1'b0, Reprogram = 1'b0, Start_Timer = 1'b0;
  logic [1:0] Time_Parameter_Selector = 2'd0, Interval = 2'd0;
  logic [3:0] Time_Value = 4'd0;
  logic       Expired, Busy, oneHz_enable;
  logic [3:0] Count, Param_Value;

  traffic_timer #(.CLKS_PER_TICK(C)) dut (
    .clk                     (clk),
    .Reset                   (Reset),
    .Reprogram               (Reprogram),
    .Time_Parameter_Selector (Time_Parameter_Selector),
    .Time_Value              (Time_Value),
    .Start_Timer             (Start_Timer),
    .Interval                (Interval),
    .Expired                 (Expired),
    .Busy                    (Busy),
    .Count                   (Count),
    .oneHz_enable            (oneHz_enable),
    .Param_Value             (Param_Value)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, exp_seen = 0;

  // Model: a countdown is "N seconds started k edges ago"; the divider phase is
  // "d edges since the last clear". Everything else is arithmetic on these.
  logic [3:0] m_params [4];
  int         m_n = 0, m_k = 0, m_d = 0;
  logic       m_run = 1'b0, m_exp = 1'b0;

  function automatic logic [3:0] def_of(input logic [1:0] s);
    case (s)
      2'd0:    return 4'd6;
      2'd1:    return 4'd3;
      2'd2:    return 4'd2;
      default: return 4'd3;
    endcase
  endfunction

  function automatic int m_count();
    if (!m_run) return 0;
    return m_n - ((m_k == 0) ? 0 : (m_k - 1) / C);
  endfunction

  function automatic logic m_tick();
    return (m_d >= C) && (m_d % C == 0);
  endfunction

  task automatic model_step(input logic rst, input logic rp, input logic [1:0] sel,
                            input logic [3:0] tv, input logic st, input logic [1:0] iv);
    m_exp = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_params[i] = def_of(2'(i));
      m_run = 1'b0; m_n = 0; m_k = 0; m_d = 0;
    end else begin
      if (st) begin
        m_n = int'(m_params[iv]); m_run = 1'b1; m_k = 0; m_d = 0;
      end else begin
        m_d++;
        if (m_run) begin
          m_k++;
          if (m_k == m_n * C + 1) begin
            m_run = 1'b0; m_exp = 1'b1;
          end
        end
      end
      if (rp) m_params[sel] = (tv != 4'd0) ? tv : def_of(sel);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cycle(input logic rst, input logic rp, input logic [1:0] sel,
                       input logic [3:0] tv, input logic st, input logic [1:0] iv);
    @(negedge clk);
    Reset = rst; Reprogram = rp; Time_Parameter_Selector = sel;
    Time_Value = tv; Start_Timer = st; Interval = iv;
    @(posedge clk);
    model_step(rst, rp, sel, tv, st, iv);
    cyc++;
    #1;
    if (Expired === 1'b1) exp_seen++;
    check($sformatf("busy@%0d", cyc),    32'(Busy),         32'(m_run));
    check($sformatf("count@%0d", cyc),   32'(Count),        32'(m_count()));
    check($sformatf("expired@%0d", cyc), 32'(Expired),      32'(m_exp));
    check($sformatf("tick@%0d", cyc),    32'(oneHz_enable), 32'(m_tick()));
    check($sformatf("param@%0d", cyc),   32'(Param_Value),  32'(m_params[sel]));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
  endtask

  task automatic start(input logic [1:0] iv);
    cycle(1'b0, 1'b0, iv, 4'd0, 1'b1, iv);
  endtask

  // Returns edges after the start edge at which Expired was seen, or -1 on timeout.
  task automatic wait_expired(input int budget, output int lat);
    int  i;
    bit  done;
    lat = -1; i = 0; done = 1'b0;
    while (!done && i < budget) begin
      i++;
      idle();
      if (Expired === 1'b1) begin
        lat = i; done = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic       rst, rp;
    logic [1:0] sel;
    logic [3:0] tv;
    logic       st;
    logic [1:0] iv;
    logic       busy;
    logic [3:0] cnt;
    logic [3:0] pv;
  } vec_t;

  vec_t vt [10];

  initial begin
    int lat, e0;

    vt[0] = '{1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 4'd6};
    vt[1] = '{1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 4'd3};
    vt[2] = '{1'b0, 1'b0, 2'd2, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 4'd2};
    vt[3] = '{1'b0, 1'b0, 2'd3, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 4'd3};
    vt[4] = '{1'b0, 1'b1, 2'd2, 4'd5, 1'b0, 2'd0, 1'b0, 4'd0, 4'd5};
    vt[5] = '{1'b0, 1'b1, 2'd3, 4'd9, 1'b0, 2'd0, 1'b0, 4'd0, 4'd9};
    vt[6] = '{1'b0, 1'b1, 2'd3, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 4'd3};
    vt[7] = '{1'b0, 1'b0, 2'd2, 4'd0, 1'b1, 2'd2, 1'b1, 4'd5, 4'd5};
    vt[8] = '{1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 4'd5, 4'd6};
    vt[9] = '{1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 4'd2};

    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].rst, vt[i].rp, vt[i].sel, vt[i].tv, vt[i].st, vt[i].iv);
      check($sformatf("vec%0d_busy", i),  32'(Busy),        32'(vt[i].busy));
      check($sformatf("vec%0d_count", i), 32'(Count),       32'(vt[i].cnt));
      check($sformatf("vec%0d_param", i), 32'(Param_Value), 32'(vt[i].pv));
    end

    // Default countdown of tBASE.
    cycle(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
    start(2'd0);
    check("base_busy", 32'(Busy), 32'd1);
    check("base_count0", 32'(Count), 32'd6);
    wait_expired(100, lat);
    check("base_latency", 32'(lat), 32'd61);
    idle();
    check("base_busy_after", 32'(Busy), 32'd0);
    check("base_count_after", 32'(Count), 32'd0);

    // Reprogram tYEL, time it, then restore via zero write.
    cycle(1'b0, 1'b1, 2'd2, 4'd5, 1'b0, 2'd0);
    check("yel_prog", 32'(Param_Value), 32'd5);
    start(2'd2);
    wait_expired(100, lat);
    check("yel_latency", 32'(lat), 32'd51);
    cycle(1'b0, 1'b1, 2'd2, 4'd0, 1'b0, 2'd0);
    check("yel_default", 32'(Param_Value), 32'd2);

    // Restart mid-run: only the second countdown expires.
    e0 = exp_seen;
    start(2'd0);
    repeat (24) idle();
    start(2'd1);
    wait_expired(100, lat);
    check("restart_latency", 32'(lat), 32'd31);
    check("restart_single_expire", 32'(exp_seen - e0), 32'd1);

    // Reset mid-run aborts and restores defaults.
    cycle(1'b0, 1'b1, 2'd1, 4'd12, 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 2'd3, 4'd8, 1'b0, 2'd0);
    start(2'd0);
    repeat (29) idle();
    cycle(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    e0 = exp_seen;
    repeat (80) idle();
    check("rst_no_expire", 32'(exp_seen - e0), 32'd0);
    for (int s = 0; s < 4; s++) begin
      cycle(1'b0, 1'b0, 2'(s), 4'd0, 1'b0, 2'd0);
      check($sformatf("rst_default%0d", s), 32'(Param_Value), 32'(def_of(2'(s))));
    end

    // Start on the final tick edge wins over expiry.
    e0 = exp_seen;
    start(2'd1);
    repeat (30) idle();
    start(2'd1);
    check("coin_no_expire", 32'(exp_seen - e0), 32'd0);
    check("coin_busy", 32'(Busy), 32'd1);
    check("coin_count", 32'(Count), 32'd3);
    // Reprogram and start on the same slot: old value loads.
    repeat (3) idle();
    cycle(1'b0, 1'b1, 2'd1, 4'd7, 1'b1, 2'd1);
    check("coin_old_value", 32'(Count), 32'd3);
    check("coin_new_param", 32'(Param_Value), 32'd7);
    wait_expired(100, lat);
    check("coin_latency", 32'(lat), 32'd31);
    start(2'd1);
    check("coin_new_load", 32'(Count), 32'd7);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 9) == 0),
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 149) == 0),
            2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_TICK, default 100_000_000, giving clk cycles per one-second tick; the bench overrides it to 10.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port Reprogram, input, 1 bit: when high, write Time_Value into the parameter slot selected by Time_Parameter_Selector.
REQ-005 The block SHALL have port Time_Parameter_Selector, input, 2 bits: parameter slot. 00 = tBASE, 01 = tEXT, 10 = tYEL, 11 = tWALK.
REQ-006 The block SHALL have port Time_Value, input, 4 bits: new parameter value in seconds.
REQ-007 The block SHALL have port Start_Timer, input, 1 bit: single-cycle request from the controller FSM to begin a countdown.
REQ-008 The block SHALL have port Interval, input, 2 bits: parameter slot used by Start_Timer, with the same encoding as Time_Parameter_Selector.
REQ-009 The block SHALL have port Expired, output, 1 bit: registered single-cycle pulse marking the end of a countdown.
REQ-010 The block SHALL have port Busy, output, 1 bit: high while a countdown is in progress.
REQ-011 The block SHALL have port Count, output, 4 bits: remaining seconds, for the display.
REQ-012 The block SHALL have port oneHz_enable, output, 1 bit: registered tick pulse, one cycle wide.
REQ-013 The block SHALL have port Param_Value, output, 4 bits: combinational read of the slot selected by Time_Parameter_Selector.

Function
REQ-014 The parameter store SHALL hold four 4-bit registers with defaults tBASE=6, tEXT=3, tYEL=2, tWALK=3.
REQ-015 On a clk edge where Reprogram=1 and Time_Value≠0, the selected slot SHALL load Time_Value.
- If Time_Value=0, the slot SHALL reload its default instead.
REQ-016 A reprogram SHALL NOT alter a countdown already running; a new value applies only from the next Start_Timer.
REQ-017 The divider SHALL count from 0 to CLKS_PER_TICK-1 and wrap to 0.
- oneHz_enable SHALL be high for exactly the one cycle after the count reaches CLKS_PER_TICK-1.
REQ-018 The timer SHALL have two states, IDLE and RUN.
- Busy=1 exactly in RUN.
REQ-019 On any edge with Start_Timer=1, in IDLE or in RUN:
- Count SHALL load the slot selected by Interval at that edge.
- The divider SHALL clear to 0.
- The state SHALL become RUN.
- A start received while in RUN restarts the countdown.
REQ-020 In RUN, each oneHz_enable pulse SHALL decrement Count by 1.
- On the pulse that takes Count from 1 to 0, the state SHALL return to IDLE.
- Expired SHALL be high for the following cycle only.
REQ-021 Latency: Expired SHALL be high exactly N*CLKS_PER_TICK+1 cycles after the Start_Timer sampling edge, where N is the loaded value.
REQ-022 If Start_Timer and the final decrementing tick coincide, the start SHALL win: no Expired pulse, and a new countdown begins.
REQ-023 If Reprogram and Start_Timer coincide on the same slot, Count SHALL load the old (pre-write) value.
REQ-024 In IDLE, Count SHALL hold 0 and ticks SHALL have no effect; the divider keeps free-running.
REQ-025 Count SHALL never underflow; arithmetic is 4-bit unsigned.

Reset
REQ-026 On a clk edge with Reset=1, the block SHALL:
- restore all parameters to their defaults;
- clear the divider to 0;
- set state to IDLE and Count=0;
- drive Expired=0, Busy=0 and oneHz_enable=0 in the next cycle.
- Reset SHALL take priority over Start_Timer and Reprogram.
REQ-027 A Reset during RUN SHALL abort the countdown with no Expired pulse.

Structure
REQ-028 A shared package SHALL hold:
- the slot encodings (BASE, EXT, YEL, WALK);
- the four default values;
- the IDLE/RUN state type.
REQ-029 The divider SHALL be a separate sub-module, one_hz_divider, with ports clk, Reset, clear and oneHz_enable, parameterised by CLKS_PER_TICK.

Verification (CLKS_PER_TICK=10)
REQ-030 Default countdown: Reset, then Start_Timer with Interval=00. Required: Busy=1; Count steps 6,5,...,1,0; Expired high exactly 61 cycles after start; then Busy=0.
REQ-031 Reprogram: Selector=10, Time_Value=5, Reprogram pulse. Required: Param_Value=5. Then start with Interval=10: Expired at cycle 51. Then reprogram with Time_Value=0: Param_Value returns to 2.
REQ-032 Restart: start with Interval=00, then start again with Interval=01 25 cycles later. Required: a single Expired, 31 cycles after the second start.
REQ-033 Reset mid-run: start with Interval=00, assert Reset at cycle 30. Required: Busy=0, Count=0, no Expired afterwards, all parameters back to defaults.
REQ-034 Coincidence: Start_Timer on the final tick edge. Required: no Expired, Count reloads, Busy stays 1. Then Reprogram on the same slot in the same cycle as Start. Required: the old value is loaded.
